// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback bus between ALU/MEM sources, arbiter and RF write port
//   alu_valid/alu_ready/alu_rd/alu_wd          : ALU writeback request channel
//   mem_valid/mem_ready/mem_rd/mem_wd/mem_op   : load writeback request channel
//   rf_wr/rf_a3/rf_wd/rf_memop                 : registered register-file write port
//   modport slave  : arbiter side
//   modport master : source / register-file side
interface rf_wb_arbiter_if #(
  parameter int DW = 32
);
  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_rd;
  logic [DW-1:0] alu_wd;
  logic          mem_valid;
  logic          mem_ready;
  logic [4:0]    mem_rd;
  logic [DW-1:0] mem_wd;
  logic [1:0]    mem_op;
  logic          rf_wr;
  logic [4:0]    rf_a3;
  logic [DW-1:0] rf_wd;
  logic [1:0]    rf_memop;

  modport slave (
    input  alu_valid, alu_rd, alu_wd,
    input  mem_valid, mem_rd, mem_wd, mem_op,
    output alu_ready, mem_ready,
    output rf_wr, rf_a3, rf_wd, rf_memop
  );

  modport master (
    output alu_valid, alu_rd, alu_wd,
    output mem_valid, mem_rd, mem_wd, mem_op,
    input  alu_ready, mem_ready,
    input  rf_wr, rf_a3, rf_wd, rf_memop
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write port arbiter with pending-write scoreboard
//   Optional forwarding outputs enabled by macro RFWB_FWD_EN.
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : ALU/MEM writeback requests and registered RF write port
//   sb_set, sb_set_addr : decode marks a destination register as pending
//   rs_addr, rt_addr    : decode source register queries
//   rs_busy, rt_busy    : source has an outstanding producer
//   fwd_rs_hit/rt_hit   : RF write this cycle targets rs/rt (forwarding build only)
//   fwd_data            : extended RF write data (forwarding build only)
//   sb_err              : sticky double-issue error
module rf_wb_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int DW         = 32
) (
  input  logic                clk,
  input  logic                rst,
  rf_wb_arbiter_if.slave      bus,
  input  logic                sb_set,
  input  logic [4:0]          sb_set_addr,
  input  logic [4:0]          rs_addr,
  input  logic [4:0]          rt_addr,
  output logic                rs_busy,
  output logic                rt_busy,
  output logic                fwd_rs_hit,
  output logic                fwd_rt_hit,
  output logic [DW-1:0]       fwd_data,
  output logic                sb_err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]    alu_wait_cnt;
  logic          alu_ready;
  logic          mem_ready;
  logic          alu_xfer;
  logic          mem_xfer;
  logic          alu_force;

  logic          rf_wr_q;
  logic [4:0]    rf_a3_q;
  logic [DW-1:0] rf_wd_q;
  logic [1:0]    rf_memop_q;

  logic [31:0]   sb;
  logic [31:0]   sb_next;
  logic          sb_err_q;
  logic          set_valid;
  logic          dup_set;

  // ALU wins a contested cycle only once it has lost STARVE_MAX times in a row.
  always_comb begin
    alu_force = bus.alu_valid && (alu_wait_cnt >= STARVE_LIM);
    alu_ready = !rst && bus.alu_valid && (!bus.mem_valid || alu_force);
    mem_ready = !rst && bus.mem_valid && !(bus.alu_valid && alu_force);
    alu_xfer  = bus.alu_valid && alu_ready;
    mem_xfer  = bus.mem_valid && mem_ready;
  end

  assign bus.alu_ready = alu_ready;
  assign bus.mem_ready = mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_wait_cnt <= 4'd0;
    end else if (!bus.alu_valid || alu_xfer) begin
      alu_wait_cnt <= 4'd0;
    end else if (alu_wait_cnt != 4'hF) begin
      alu_wait_cnt <= alu_wait_cnt + 4'd1;
    end
  end

  // Writes to r0 are consumed without pulsing rf_wr; address/data then hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_q    <= 1'b0;
      rf_a3_q    <= 5'd0;
      rf_wd_q    <= '0;
      rf_memop_q <= 2'b00;
    end else begin
      rf_wr_q <= 1'b0;
      if (alu_xfer && bus.alu_rd != 5'd0) begin
        rf_wr_q    <= 1'b1;
        rf_a3_q    <= bus.alu_rd;
        rf_wd_q    <= bus.alu_wd;
        rf_memop_q <= 2'b00;
      end else if (mem_xfer && bus.mem_rd != 5'd0) begin
        rf_wr_q    <= 1'b1;
        rf_a3_q    <= bus.mem_rd;
        rf_wd_q    <= bus.mem_wd;
        rf_memop_q <= bus.mem_op;
      end
    end
  end

  assign bus.rf_wr    = rf_wr_q;
  assign bus.rf_a3    = rf_a3_q;
  assign bus.rf_wd    = rf_wd_q;
  assign bus.rf_memop = rf_memop_q;

  // Clear is applied before set so a re-issue in the retire cycle keeps the bit.
  always_comb begin
    set_valid = sb_set && (sb_set_addr != 5'd0);
    dup_set   = set_valid && sb[sb_set_addr] && !(rf_wr_q && (rf_a3_q == sb_set_addr));
    sb_next   = sb;
    if (rf_wr_q) sb_next[rf_a3_q] = 1'b0;
    if (set_valid) sb_next[sb_set_addr] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb       <= 32'd0;
      sb_err_q <= 1'b0;
    end else begin
      sb <= sb_next;
      if (dup_set) sb_err_q <= 1'b1;
    end
  end

  assign sb_err = sb_err_q;

`ifdef RFWB_FWD_EN
  always_comb begin
    case (rf_memop_q)
      2'b01:   fwd_data = {{(DW-8){rf_wd_q[7]}}, rf_wd_q[7:0]};
      2'b10:   fwd_data = {{(DW-16){rf_wd_q[15]}}, rf_wd_q[15:0]};
      default: fwd_data = rf_wd_q;
    endcase
    fwd_rs_hit = rf_wr_q && (rf_a3_q == rs_addr) && (rs_addr != 5'd0);
    fwd_rt_hit = rf_wr_q && (rf_a3_q == rt_addr) && (rt_addr != 5'd0);
    // A register being written this cycle is served by forwarding, not stalled.
    rs_busy    = (rs_addr != 5'd0) && sb[rs_addr] && !fwd_rs_hit;
    rt_busy    = (rt_addr != 5'd0) && sb[rt_addr] && !fwd_rt_hit;
  end
`else
  always_comb begin
    fwd_data   = '0;
    fwd_rs_hit = 1'b0;
    fwd_rt_hit = 1'b0;
    rs_busy    = (rs_addr != 5'd0) && sb[rs_addr];
    rt_busy    = (rt_addr != 5'd0) && sb[rt_addr];
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          sb_set;
  logic [4:0]    sb_set_addr;
  logic [4:0]    rs_addr;
  logic [4:0]    rt_addr;
  logic          rs_busy;
  logic          rt_busy;
  logic          fwd_rs_hit;
  logic          fwd_rt_hit;
  logic [DW-1:0] fwd_data;
  logic          sb_err;

  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.DW(DW)) bus ();

  rf_wb_arbiter #(.STARVE_MAX(STARVE_MAX), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .fwd_rs_hit  (fwd_rs_hit),
    .fwd_rt_hit  (fwd_rt_hit),
    .fwd_data    (fwd_data),
    .sb_err      (sb_err)
  );

  typedef struct {
    logic          wr;
    logic [4:0]    a3;
    logic [DW-1:0] wd;
    logic [1:0]    op;
  } wr_t;

  wr_t           exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  int            m_wait = 0;
  logic [31:0]   m_sb   = 32'd0;
  logic          m_err  = 1'b0;
  logic          m_wr   = 1'b0;
  logic [4:0]    m_a3   = 5'd0;
  logic [DW-1:0] m_wd   = '0;
  logic [1:0]    m_op   = 2'b00;
  logic          g_alu  = 1'b0;
  logic          g_mem  = 1'b0;
  logic          d_alu_ready;
  logic          d_mem_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] sext(input logic [DW-1:0] d, input logic [1:0] op);
    if (op == 2'b01) return {{(DW-8){d[7]}}, d[7:0]};
    if (op == 2'b10) return {{(DW-16){d[15]}}, d[15:0]};
    return d;
  endfunction

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [DW-1:0] wd);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_wd    = wd;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] rd, input logic [DW-1:0] wd,
                         input logic [1:0] op);
    bus.mem_valid = v;
    bus.mem_rd    = rd;
    bus.mem_wd    = wd;
    bus.mem_op    = op;
  endtask

  // One clock: check readies, push expected write, clock, pop and check outputs.
  task automatic cycle();
    wr_t  e;
    wr_t  o;
    logic ea;
    logic em;
    logic eb_rs;
    logic eb_rt;
    logic h_rs;
    logic h_rt;
    logic [DW-1:0] efd;
    #1;
    ea = !rst && bus.alu_valid && (!bus.mem_valid || (m_wait >= STARVE_MAX));
    em = !rst && bus.mem_valid && !ea;
    d_alu_ready = bus.alu_ready;
    d_mem_ready = bus.mem_ready;
    check("alu_ready", 32'(bus.alu_ready), 32'(ea));
    check("mem_ready", 32'(bus.mem_ready), 32'(em));
    g_alu = ea;
    g_mem = em;

    e = '{1'b0, m_a3, m_wd, m_op};
    if (rst)                              e = '{1'b0, 5'd0, '0, 2'b00};
    else if (ea && bus.alu_rd != 5'd0)    e = '{1'b1, bus.alu_rd, bus.alu_wd, 2'b00};
    else if (em && bus.mem_rd != 5'd0)    e = '{1'b1, bus.mem_rd, bus.mem_wd, bus.mem_op};
    exp_q.push_back(e);

    if (rst) begin
      m_wait = 0;
      m_sb   = 32'd0;
      m_err  = 1'b0;
    end else begin
      if (sb_set && sb_set_addr != 5'd0 && m_sb[sb_set_addr] && !(m_wr && m_a3 == sb_set_addr))
        m_err = 1'b1;
      if (m_wr) m_sb[m_a3] = 1'b0;
      if (sb_set && sb_set_addr != 5'd0) m_sb[sb_set_addr] = 1'b1;
      if (!bus.alu_valid || ea) m_wait = 0;
      else if (m_wait < 15) m_wait++;
    end

    @(posedge clk);
    #1;
    check("queue_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      o = exp_q.pop_front();
      check("rf_wr", 32'(bus.rf_wr), 32'(o.wr));
      check("rf_a3", 32'(bus.rf_a3), 32'(o.a3));
      check("rf_wd", bus.rf_wd, o.wd);
      check("rf_memop", 32'(bus.rf_memop), 32'(o.op));
      m_wr = o.wr;
      m_a3 = o.a3;
      m_wd = o.wd;
      m_op = o.op;
    end

    eb_rs = (rs_addr != 5'd0) && m_sb[rs_addr];
    eb_rt = (rt_addr != 5'd0) && m_sb[rt_addr];
`ifdef RFWB_FWD_EN
    h_rs = m_wr && m_a3 == rs_addr && rs_addr != 5'd0;
    h_rt = m_wr && m_a3 == rt_addr && rt_addr != 5'd0;
    efd  = sext(m_wd, m_op);
    if (h_rs) eb_rs = 1'b0;
    if (h_rt) eb_rt = 1'b0;
`else
    h_rs = 1'b0;
    h_rt = 1'b0;
    efd  = '0;
`endif
    check("rs_busy", 32'(rs_busy), 32'(eb_rs));
    check("rt_busy", 32'(rt_busy), 32'(eb_rt));
    check("fwd_rs_hit", 32'(fwd_rs_hit), 32'(h_rs));
    check("fwd_rt_hit", 32'(fwd_rt_hit), 32'(h_rt));
    check("fwd_data", fwd_data, efd);
    check("sb_err", 32'(sb_err), 32'(m_err));
  endtask

  initial begin
    logic [3:0] alu_log;
    logic [3:0] mem_log;

    rst         = 1'b1;
    sb_set      = 1'b0;
    sb_set_addr = 5'd0;
    rs_addr     = 5'd0;
    rt_addr     = 5'd0;
    set_alu(1'b1, 5'd3, 32'h1111_1111);
    set_mem(1'b1, 5'd4, 32'h2222_2222, 2'b00);

    // Reset with both sources requesting; sweep every rs/rt address.
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      cycle();
      check("rst_rs_busy", 32'(rs_busy), 32'd0);
    end
    check("rst_rf_a3", 32'(bus.rf_a3), 32'd0);
    check("rst_rf_wd", bus.rf_wd, 32'd0);

    // Single ALU write.
    rst = 1'b0;
    set_mem(1'b0, 5'd0, '0, 2'b00);
    set_alu(1'b1, 5'd5, 32'h1234_5678);
    cycle();
    check("t2_alu_ready", 32'(d_alu_ready), 32'd1);
    check("t2_rf_wr", 32'(bus.rf_wr), 32'd1);
    check("t2_rf_a3", 32'(bus.rf_a3), 32'd5);
    check("t2_rf_wd", bus.rf_wd, 32'h1234_5678);
    check("t2_rf_memop", 32'(bus.rf_memop), 32'd0);
    set_alu(1'b0, 5'd0, '0);
    cycle();

    // Contention: MEM wins three times, then ALU is forced through.
    set_alu(1'b1, 5'd6, 32'hA000_0006);
    alu_log = 4'd0;
    mem_log = 4'd0;
    for (int k = 0; k < 4; k++) begin
      set_mem(1'b1, 5'(10 + k), 32'hB000_0000 + 32'(k), 2'b00);
      cycle();
      alu_log[k] = d_alu_ready;
      mem_log[k] = d_mem_ready;
    end
    check("t3_alu_grants", 32'(alu_log), 32'b1000);
    check("t3_mem_grants", 32'(mem_log), 32'b0111);
    set_alu(1'b1, 5'd7, 32'hA000_0007);
    cycle();
    check("t3_mem_after_alu", 32'(d_mem_ready), 32'd1);
    set_alu(1'b0, 5'd0, '0);
    set_mem(1'b0, 5'd0, '0, 2'b00);
    cycle();

    // Scoreboard set/clear/reissue/duplicate.
    sb_set = 1'b1; sb_set_addr = 5'd8; rs_addr = 5'd8; rt_addr = 5'd0;
    cycle();
    check("t4_busy_set", 32'(rs_busy), 32'd1);
    sb_set = 1'b0;
    set_mem(1'b1, 5'd8, 32'h0000_00F0, 2'b01);
    cycle();
    set_mem(1'b0, 5'd0, '0, 2'b00);
    sb_set = 1'b1;
    cycle();
    check("t4_busy_kept", 32'(rs_busy), 32'd1);
    check("t4_no_err", 32'(sb_err), 32'd0);
    cycle();
    check("t4_sb_err", 32'(sb_err), 32'd1);
    sb_set = 1'b0;

    // Write to r0 is accepted but never reaches the RF.
    set_alu(1'b1, 5'd0, 32'hDEAD_BEEF);
    cycle();
    check("t5_ready", 32'(d_alu_ready), 32'd1);
    check("t5_no_wr", 32'(bus.rf_wr), 32'd0);
    set_alu(1'b0, 5'd0, '0);

    // Forwarding of a sign-extended halfword.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_err_cleared", 32'(sb_err), 32'd0);
    sb_set = 1'b1; sb_set_addr = 5'd9; rs_addr = 5'd9;
    cycle();
    sb_set = 1'b0;
    set_mem(1'b1, 5'd9, 32'h0000_80FF, 2'b10);
    cycle();
`ifdef RFWB_FWD_EN
    check("t6_fwd_hit", 32'(fwd_rs_hit), 32'd1);
    check("t6_fwd_data", fwd_data, 32'hFFFF_80FF);
    check("t6_rs_busy", 32'(rs_busy), 32'd0);
`else
    check("t6_fwd_hit", 32'(fwd_rs_hit), 32'd0);
    check("t6_rs_busy", 32'(rs_busy), 32'd1);
`endif
    set_mem(1'b0, 5'd0, '0, 2'b00);
    cycle();
    check("t6_busy_cleared", 32'(rs_busy), 32'd0);

    // Reset during a transfer drops the write.
    set_alu(1'b1, 5'd12, 32'h0C0C_0C0C);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_alu(1'b0, 5'd0, '0);
    check("rst_drop_wr", 32'(bus.rf_wr), 32'd0);
    cycle();
    check("rst_drop_wr2", 32'(bus.rf_wr), 32'd0);

    // Random traffic honouring the hold-until-ready rule.
    for (int n = 0; n < 400; n++) begin
      if (!bus.alu_valid || g_alu)
        set_alu(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), DW'($urandom));
      if (!bus.mem_valid || g_mem)
        set_mem(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), DW'($urandom),
                2'($urandom_range(0, 3)));
      sb_set      = 1'($urandom_range(0, 3) == 0);
      sb_set_addr = 5'($urandom_range(0, 31));
      rs_addr     = 5'($urandom_range(0, 31));
      rt_addr     = 5'($urandom_range(0, 31));
      rst         = 1'($urandom_range(0, 99) == 0);
      cycle();
    end
    rst    = 1'b0;
    sb_set = 1'b0;
    set_alu(1'b0, 5'd0, '0);
    set_mem(1'b0, 5'd0, '0, 2'b00);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (RFWr/A3/WD/memOp) between two writeback sources: the ALU result path and the memory load path.
- Keeps a 32-entry pending-write scoreboard so the decode stage can stall on a RAW hazard against an outstanding producer.
- Sits between the execute/memory stages and the register file. Drives the RF write port from registered outputs.

Parameters:
- STARVE_MAX, 3: consecutive cycles an ALU request may lose to MEM before it is forced to win; legal range 1..15.
- DW, 32: data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_wd  in  DW  ALU result.
- mem_valid  in  1  load writeback request.
- mem_ready  out  1  load request accepted this cycle.
- mem_rd  in  5  load destination register.
- mem_wd  in  DW  raw load data.
- mem_op  in  2  00/11 = word, 01 = byte signed, 10 = half signed.
- rf_wr  out  1  RF write enable (to RFWr).
- rf_a3  out  5  RF write address.
- rf_wd  out  DW  RF write data.
- rf_memop  out  2  RF extension select; 00 for ALU writes.
- sb_set  in  1  decode issues an instruction writing sb_set_addr.
- sb_set_addr  in  5  destination being issued.
- rs_addr  in  5  decode source register 1 query.
- rt_addr  in  5  decode source register 2 query.
- rs_busy  out  1  rs has a pending write.
- rt_busy  out  1  rt has a pending write.
- fwd_rs_hit  out  1  forwarding hit for rs (see Optional Feature).
- fwd_rt_hit  out  1  forwarding hit for rt (see Optional Feature).
- fwd_data  out  DW  forwarded, extended write data (see Optional Feature).
- sb_err  out  1  sticky flag: sb_set hit an already-pending register.

Behaviour:
- Reset values (on rst at posedge): rf_wr=0, rf_a3=0, rf_wd=0, rf_memop=0, scoreboard all 0, alu_wait_cnt=0, sb_err=0.
- While rst is high: alu_ready=0 and mem_ready=0. Reset mid-transfer drops any in-flight write; no rf_wr pulse follows.

Handshake:
- A source holds valid, rd and data stable until it sees ready=1.
- Transfer occurs on a cycle where valid&&ready at posedge.
- ready is combinational from the valid inputs and alu_wait_cnt.

Grant rules:
- Only one source valid: that source is granted.
- Both valid: MEM is granted, unless alu_wait_cnt >= STARVE_MAX, in which case ALU is granted.
- Exactly one source is granted per cycle.

alu_wait_cnt (4-bit):
- +1 when alu_valid && !alu_ready, saturating at 15.
- Cleared when an ALU transfer occurs or alu_valid=0.

Output stage (1-cycle latency):
- On a transfer with rd!=0: next cycle rf_wr=1, rf_a3=rd, rf_wd=data, rf_memop=mem_op for MEM or 00 for ALU.
- On a transfer with rd==0: the transfer is consumed but rf_wr stays 0 (no write to r0).
- With no transfer, rf_wr=0; rf_a3, rf_wd and rf_memop hold their last values.

Scoreboard (32 bits; bit 0 hard-wired 0):
- Set: sb_set with sb_set_addr!=0 sets sb[sb_set_addr].
- Clear: sb[rf_a3] is cleared on a cycle where rf_wr=1.
- Set and clear of the same address in the same cycle: set wins, so the bit stays 1.
- sb_err: set when sb_set targets a bit that is already 1 and is not being cleared that cycle; stays set until rst.

Busy outputs:
- rs_busy = (rs_addr!=0) && sb[rs_addr].
- rt_busy = (rt_addr!=0) && sb[rt_addr].
- Both are combinational from the current scoreboard state; the clear takes effect the cycle after rf_wr.

Optional Feature:
- Macro: RFWB_FWD_EN.

With the macro defined:
- fwd_data = rf_wd extended per rf_memop: 01 gives sign-extended [7:0], 10 gives sign-extended [15:0], 00/11 pass through unchanged.
- fwd_rs_hit = rf_wr && rf_a3==rs_addr && rs_addr!=0.
- fwd_rt_hit = rf_wr && rf_a3==rt_addr && rt_addr!=0.
- On a hit, the matching rs_busy/rt_busy is forced to 0 that cycle.

Without the macro:
- fwd_rs_hit=0, fwd_rt_hit=0, fwd_data=0.
- Busy outputs follow the plain scoreboard rules only.

Test Plan:
1. Reset: assert rst for 2 cycles with both valids high -> readies 0, rf_wr 0, rs_busy 0 for every rs_addr, sb_err 0.
2. Single ALU write: alu_valid, alu_rd=5, alu_wd=0x12345678 -> alu_ready same cycle; next cycle rf_wr=1, rf_a3=5, rf_wd=0x12345678, rf_memop=00.
3. Arbitration with STARVE_MAX=3: both valid continuously -> MEM granted for cycles 1-3, ALU granted in cycle 4, alu_wait_cnt back to 0.
4. Scoreboard: sb_set addr 8, then a MEM transfer rd=8 mem_op=01 -> rs_busy(rs_addr=8)=1 until the cycle after rf_wr; a new sb_set addr 8 in the rf_wr cycle keeps it busy; a second sb_set addr 8 with no clear -> sb_err=1.
5. r0 write: ALU transfer with alu_rd=0 -> ready=1, no rf_wr pulse, scoreboard unchanged.
6. RFWB_FWD_EN: MEM write rd=9, mem_wd=0x000080FF, mem_op=10, rs_addr=9 in the rf_wr cycle -> fwd_rs_hit=1, fwd_data=0xFFFF80FF, rs_busy=0; without the macro -> fwd_rs_hit=0, rs_busy=1.
